// File: rtl/vertex_sequencer.sv
// vertex_sequencer: drives the transform engine one vertex at a time and
// streams each triangle's three edges to the line rasterizer.
// Ports: clock, reset (sync, active-high); frame_start, pose_changed in;
// vert_addr/vert_data vertex memory read; xf_* engine start/done and results;
// line_valid/line_ready with line_x0/y0/x1/y1 edges; busy, frame_done status.
// Optional macro BACKFACE_CULL_EN: drop triangles whose signed area is <= 0.
module vertex_sequencer #(
    parameter int NUM_VERTS = 36,
    parameter int ADDR_W    = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pose_changed,
    output logic [ADDR_W-1:0] vert_addr,
    input  logic [95:0]       vert_data,
    output logic              xf_start,
    output logic              xf_update_mvp,
    output logic [31:0]       xf_x,
    output logic [31:0]       xf_y,
    output logic [31:0]       xf_z,
    input  logic              xf_done,
    input  logic [31:0]       xf_ox,
    input  logic [31:0]       xf_oy,
    input  logic [31:0]       xf_oz,
    output logic              line_valid,
    input  logic              line_ready,
    output logic [31:0]       line_x0,
    output logic [31:0]       line_y0,
    output logic [31:0]       line_x1,
    output logic [31:0]       line_y1,
    output logic              busy,
    output logic              frame_done
);
    localparam int IW = ADDR_W + 1;
    localparam int TRI_VERTS = 3 * (NUM_VERTS / 3);
    localparam logic [IW-1:0] LAST_IDX = IW'(TRI_VERTS);

    typedef enum logic [3:0] {
        S_IDLE, S_MVP_START, S_MVP_GUARD, S_MVP_WAIT,
        S_FETCH, S_FETCH_WAIT, S_XF_START, S_XF_GUARD,
        S_XF_WAIT, S_CAPTURE, S_CULL, S_EMIT0,
        S_EMIT1, S_EMIT2, S_DONE
    } state_t;

    state_t             state_q, state_d, after_tri;
    logic [IW-1:0]      index_q, index_d;
    logic [1:0]         slot_q, slot_d;
    logic               mvp_dirty_q, mvp_dirty_d;
    logic [ADDR_W-1:0]  vert_addr_q, vert_addr_d;
    logic [31:0]        xf_x_q, xf_x_d, xf_y_q, xf_y_d, xf_z_q, xf_z_d;
    logic [2:0][31:0]   px_q, px_d, py_q, py_d;
    logic               line_valid_q, line_valid_d;
    logic [31:0]        lx0_q, lx0_d, ly0_q, ly0_d;
    logic [31:0]        lx1_q, lx1_d, ly1_q, ly1_d;
    logic               unused_oz;

    assign unused_oz = ^xf_oz;

`ifdef BACKFACE_CULL_EN
    logic signed [63:0] ax1, ay1, ax2, ay2, area;

    function automatic logic signed [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    always_comb begin
        ax1  = sx(px_q[1]) - sx(px_q[0]);
        ay1  = sx(py_q[1]) - sx(py_q[0]);
        ax2  = sx(px_q[2]) - sx(px_q[0]);
        ay2  = sx(py_q[2]) - sx(py_q[0]);
        area = ax1 * ay2 - ax2 * ay1;
    end
`endif

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        slot_d      = slot_q;
        mvp_dirty_d = mvp_dirty_q | pose_changed;
        vert_addr_d = vert_addr_q;
        xf_x_d      = xf_x_q;
        xf_y_d      = xf_y_q;
        xf_z_d      = xf_z_q;
        px_d        = px_q;
        py_d        = py_q;
        lx0_d       = lx0_q;
        ly0_d       = ly0_q;
        lx1_d       = lx1_q;
        ly1_d       = ly1_q;
        after_tri   = (index_q == LAST_IDX) ? S_DONE : S_FETCH;
        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    index_d = '0;
                    slot_d  = '0;
                    if (mvp_dirty_q)         state_d = S_MVP_START;
                    else if (TRI_VERTS == 0) state_d = S_DONE;
                    else                     state_d = S_FETCH;
                end
            end
            // Starts wait for an idle engine so xf_start never hits a busy one.
            S_MVP_START: begin
                if (xf_done) begin
                    state_d     = S_MVP_GUARD;
                    mvp_dirty_d = pose_changed;
                end
            end
            S_MVP_GUARD: state_d = S_MVP_WAIT;
            S_MVP_WAIT: begin
                if (xf_done) state_d = (TRI_VERTS == 0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                xf_x_d  = vert_data[95:64];
                xf_y_d  = vert_data[63:32];
                xf_z_d  = vert_data[31:0];
                state_d = S_XF_START;
            end
            S_XF_START: if (xf_done) state_d = S_XF_GUARD;
            S_XF_GUARD: state_d = S_XF_WAIT;
            S_XF_WAIT:  if (xf_done) state_d = S_CAPTURE;
            S_CAPTURE: begin
                px_d[slot_q] = xf_ox;
                py_d[slot_q] = xf_oy;
                index_d      = index_q + 1'b1;
                if (slot_q == 2'd2) begin
                    slot_d = '0;
`ifdef BACKFACE_CULL_EN
                    state_d = S_CULL;
`else
                    state_d = S_EMIT0;
`endif
                end else begin
                    slot_d  = slot_q + 2'd1;
                    state_d = S_FETCH;
                end
            end
`ifdef BACKFACE_CULL_EN
            S_CULL: state_d = (area > 0) ? S_EMIT0 : after_tri;
`endif
            S_EMIT0: if (line_ready) state_d = S_EMIT1;
            S_EMIT1: if (line_ready) state_d = S_EMIT2;
            S_EMIT2: if (line_ready) state_d = after_tri;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_FETCH) vert_addr_d = index_d[ADDR_W-1:0];

        // Endpoints load on entry to each emit state and hold while stalled.
        line_valid_d = 1'b0;
        case (state_d)
            S_EMIT0: begin
                line_valid_d = 1'b1;
                lx0_d = px_q[0]; ly0_d = py_q[0];
                lx1_d = px_q[1]; ly1_d = py_q[1];
            end
            S_EMIT1: begin
                line_valid_d = 1'b1;
                lx0_d = px_q[1]; ly0_d = py_q[1];
                lx1_d = px_q[2]; ly1_d = py_q[2];
            end
            S_EMIT2: begin
                line_valid_d = 1'b1;
                lx0_d = px_q[2]; ly0_d = py_q[2];
                lx1_d = px_q[0]; ly1_d = py_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            index_q      <= '0;
            slot_q       <= '0;
            mvp_dirty_q  <= 1'b1;
            vert_addr_q  <= '0;
            xf_x_q       <= '0;
            xf_y_q       <= '0;
            xf_z_q       <= '0;
            px_q         <= '0;
            py_q         <= '0;
            line_valid_q <= 1'b0;
            lx0_q        <= '0;
            ly0_q        <= '0;
            lx1_q        <= '0;
            ly1_q        <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            slot_q       <= slot_d;
            mvp_dirty_q  <= mvp_dirty_d;
            vert_addr_q  <= vert_addr_d;
            xf_x_q       <= xf_x_d;
            xf_y_q       <= xf_y_d;
            xf_z_q       <= xf_z_d;
            px_q         <= px_d;
            py_q         <= py_d;
            line_valid_q <= line_valid_d;
            lx0_q        <= lx0_d;
            ly0_q        <= ly0_d;
            lx1_q        <= lx1_d;
            ly1_q        <= ly1_d;
        end
    end

    assign xf_update_mvp = (state_q == S_MVP_START);
    assign xf_start      = xf_done &&
                           (state_q == S_MVP_START || state_q == S_XF_START);
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done    = (state_q == S_DONE);
    assign vert_addr     = vert_addr_q;
    assign xf_x          = xf_x_q;
    assign xf_y          = xf_y_q;
    assign xf_z          = xf_z_q;
    assign line_valid    = line_valid_q;
    assign line_x0       = lx0_q;
    assign line_y0       = ly0_q;
    assign line_x1       = lx1_q;
    assign line_y1       = ly1_q;
endmodule
